// File: rtl/wt_dcache_flush_seq.sv
// wt_dcache_flush_seq
// Flush / invalidation sequencer for the write-through L1 data cache.
// It holds off new traffic, waits for the write buffer, read controllers and
// miss unit to go quiet, then walks every set index through the cache-line
// write port and clears all ways. It also owns the effective cache enable.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             flush request level from the core
//   flush_ack_o         one-cycle flush-complete pulse
//   enable_i            CSR cache enable
//   cache_en_o          effective cache enable for controllers / write buffer
//   wbuffer_empty_i     write buffer empty
//   ctrl_busy_i         any read controller busy
//   miss_pending_i      miss unit has outstanding transactions
//   hold_o              stall new requests into controllers / miss unit
//   busy_o              sequencer not idle
//   inv_req_o           invalidate request to the cache-line write port
//   inv_idx_o           set index being invalidated
//   inv_we_o            way enables (all ways while inv_req_o is high)
//   inv_ack_i           write port accepted this cycle's invalidate
module wt_dcache_flush_seq #(
    parameter int unsigned NumSets  = 256,
    parameter int unsigned NumWays  = 8,
    parameter int unsigned IdxWidth = $clog2(NumSets)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    output logic                flush_ack_o,
    input  logic                enable_i,
    output logic                cache_en_o,
    input  logic                wbuffer_empty_i,
    input  logic                ctrl_busy_i,
    input  logic                miss_pending_i,
    output logic                hold_o,
    output logic                busy_o,
    output logic                inv_req_o,
    output logic [IdxWidth-1:0] inv_idx_o,
    output logic [NumWays-1:0]  inv_we_o,
    input  logic                inv_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWEEP,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] cnt_q, cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                ack_mask_q, ack_mask_d;
    logic                cache_en_q, cache_en_d;

    logic flush_req;
    logic drained;
    logic last_idx;

    // The core may keep flush_i high for one cycle after the ack; ack_mask
    // hides that stale level so it does not start a second sweep.
    assign flush_req = flush_i & ~ack_mask_q;
    assign drained   = wbuffer_empty_i & ~ctrl_busy_i & ~miss_pending_i;
    assign last_idx  = (cnt_q == IdxWidth'(NumSets - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        ack_mask_d   = 1'b0;
        cache_en_d   = cache_en_q;

        unique case (state_q)
            IDLE: begin
                if (flush_req || (cache_en_q && !enable_i)) begin
                    // Flush and disable share one sweep; the enable drops
                    // on the same edge as hold rises.
                    state_d = DRAIN;
                    if (flush_req) flush_pend_d = 1'b1;
                    if (!enable_i) cache_en_d = 1'b0;
                end else if (enable_i) begin
                    // Enabling needs no sweep: lines were cleared when the
                    // cache was last disabled and hold prevented refills.
                    cache_en_d = 1'b1;
                end
            end
            DRAIN: begin
                // A flush arriving while hold is up merges into this sweep.
                if (flush_req) flush_pend_d = 1'b1;
                if (drained) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (flush_req) flush_pend_d = 1'b1;
                if (inv_ack_i) begin
                    cnt_d = cnt_q + IdxWidth'(1);  // wraps to 0 after last set
                    if (last_idx) state_d = DONE;
                end
            end
            DONE: begin
                // A request visible here is the one being acked (flush_pend
                // already set); the ack comes from registered state only.
                cache_en_d   = enable_i;
                flush_pend_d = 1'b0;
                ack_mask_d   = flush_pend_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Reset goes straight into a sweep: cache contents are unknown
            // and nothing can be in flight yet, so DRAIN is skipped.
            state_q      <= SWEEP;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            ack_mask_q   <= 1'b0;
            cache_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            ack_mask_q   <= ack_mask_d;
            cache_en_q   <= cache_en_d;
        end
    end

    // Outputs depend on registered state only, plus gating while in reset.
    assign busy_o      = rst_i | (state_q != IDLE);
    assign hold_o      = rst_i | (state_q != IDLE);
    assign inv_req_o   = ~rst_i & (state_q == SWEEP);
    assign inv_idx_o   = cnt_q;
    assign inv_we_o    = {NumWays{inv_req_o}};
    assign flush_ack_o = ~rst_i & (state_q == DONE) & flush_pend_q;
    assign cache_en_o  = ~rst_i & cache_en_q;

endmodule
